// File: rtl/image_scaler_if.sv
// Frame-buffer and control handshake bundle for image_scaler.
// The master side is the environment (control block plus source RAM); the slave side is the scaler.
interface image_scaler_if #(
    parameter int PIX_W = 8,
    parameter int R_AW  = 15,
    parameter int W_AW  = 17
) ();
    logic             START;
    logic [1:0]       ALGORITHM;
    logic [PIX_W-1:0] PIXEL_IN;
    logic [R_AW-1:0]  R_ADDR;
    logic             R_EN;
    logic [PIX_W-1:0] PIXEL_OUT;
    logic [W_AW-1:0]  W_ADDR;
    logic             W_EN;
    logic             BUSY;
    logic             done;

    modport master (
        output START, ALGORITHM, PIXEL_IN,
        input  R_ADDR, R_EN, PIXEL_OUT, W_ADDR, W_EN, BUSY, done
    );

    modport slave (
        input  START, ALGORITHM, PIXEL_IN,
        output R_ADDR, R_EN, PIXEL_OUT, W_ADDR, W_EN, BUSY, done
    );
endinterface

// File: rtl/image_scaler.sv
// Power-of-two image scaler: nearest-neighbour, pixel replication, decimation, block average.
// Build option SCALER_ROUND_EN: block average rounds half up instead of truncating.
//
// state  | meaning
// S_IDLE | waiting for START after reset
// S_RD   | R_EN high, R_ADDR presented to source RAM
// S_WAIT | RD_LAT cycles for source data; captures PIXEL_IN on the last one
// S_WR   | W_EN high, one destination pixel per cycle
// S_DONE | frame complete, done held until next START
module image_scaler #(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int PIX_W  = 8,
    parameter int F_LOG2 = 1,
    parameter int RD_LAT = 1,
    parameter int R_AW   = 15,
    parameter int W_AW   = 17
) (
    input logic CLK,
    input logic RESET,
    image_scaler_if.slave bus
);
    localparam int K    = 1 << F_LOG2;
    localparam int AC_W = PIX_W + 2 * F_LOG2;
    localparam logic [2:0]      K_M1     = 3'(K - 1);
    localparam logic [W_AW-1:0] SRC_W_A  = W_AW'(SRC_W);
    localparam logic [W_AW-1:0] UP_W     = W_AW'(SRC_W << F_LOG2);
    localparam logic [W_AW-1:0] DN_W     = W_AW'(SRC_W >> F_LOG2);
    localparam logic [W_AW-1:0] SRC_W_M1 = W_AW'(SRC_W - 1);
    localparam logic [W_AW-1:0] SRC_H_M1 = W_AW'(SRC_H - 1);
    localparam logic [W_AW-1:0] UP_W_M1  = W_AW'((SRC_W << F_LOG2) - 1);
    localparam logic [W_AW-1:0] UP_H_M1  = W_AW'((SRC_H << F_LOG2) - 1);
    localparam logic [W_AW-1:0] DN_W_M1  = W_AW'((SRC_W >> F_LOG2) - 1);
    localparam logic [W_AW-1:0] DN_H_M1  = W_AW'((SRC_H >> F_LOG2) - 1);
`ifdef SCALER_ROUND_EN
    localparam logic [AC_W-1:0] RND = AC_W'(1) << (2 * F_LOG2 - 1);
`else
    localparam logic [AC_W-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {ALG_NN, ALG_PR, ALG_DC, ALG_BA} alg_t;
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

    state_t           state;
    alg_t             alg;
    logic [W_AW-1:0]  ox, oy, base_r, base_w, off;
    logic [2:0]       i, j;
    logic [1:0]       wait_cnt;
    logic [AC_W-1:0]  acc;
    logic [R_AW-1:0]  r_addr;
    logic [W_AW-1:0]  w_addr;
    logic [PIX_W-1:0] pixel_out;
    logic             r_en, w_en, busy, done;

    logic [W_AW-1:0]  ox_max, oy_max, r_step, w_step, stride;
    logic [W_AW-1:0]  ox_n, oy_n, base_r_n, base_w_n, off_n;
    logic [2:0]       i_n, j_n;
    logic             i_last, inner_last, ox_last, frame_last;
    logic [AC_W-1:0]  ba_sum;
    logic [PIX_W-1:0] ba_out;

    // Outer counters walk the destination raster, except PR which walks the source raster.
    always_comb begin
        ox_max = DN_W_M1;
        oy_max = DN_H_M1;
        r_step = SRC_W_A << F_LOG2;
        w_step = DN_W;
        stride = '0;
        case (alg)
            ALG_NN: begin
                ox_max = UP_W_M1;
                oy_max = UP_H_M1;
                r_step = (oy[F_LOG2-1:0] == '1) ? SRC_W_A : '0;
                w_step = UP_W;
            end
            ALG_PR: begin
                ox_max = SRC_W_M1;
                oy_max = SRC_H_M1;
                r_step = SRC_W_A;
                w_step = UP_W << F_LOG2;
                stride = UP_W;
            end
            ALG_BA:  stride = SRC_W_A;
            default: stride = '0;
        endcase
        i_last     = (i == K_M1);
        inner_last = i_last && (j == K_M1);
        i_n        = i_last ? 3'd0 : i + 3'd1;
        j_n        = !i_last ? j : (inner_last ? 3'd0 : j + 3'd1);
        off_n      = !i_last ? off : (inner_last ? '0 : off + stride);
        ox_last    = (ox == ox_max);
        frame_last = ox_last && (oy == oy_max);
        ox_n       = ox_last ? '0 : ox + 1'b1;
        oy_n       = ox_last ? oy + 1'b1 : oy;
        base_r_n   = ox_last ? base_r + r_step : base_r;
        base_w_n   = ox_last ? base_w + w_step : base_w;
        ba_sum     = acc + AC_W'(bus.PIXEL_IN);
        ba_out     = PIX_W'((ba_sum + RND) >> (2 * F_LOG2));
    end

    function automatic logic [R_AW-1:0] rd_addr(alg_t a, logic [W_AW-1:0] br,
                                                 logic [W_AW-1:0] x, logic [W_AW-1:0] o,
                                                 logic [2:0] ii);
        logic [W_AW-1:0] col;
        case (a)
            ALG_NN:  col = x >> F_LOG2;
            ALG_PR:  col = x;
            default: col = x << F_LOG2;
        endcase
        if (a == ALG_BA) col = col + o + W_AW'(ii);
        return R_AW'(br + col);
    endfunction

    function automatic logic [W_AW-1:0] wr_addr(alg_t a, logic [W_AW-1:0] bw,
                                                logic [W_AW-1:0] x, logic [W_AW-1:0] o,
                                                logic [2:0] ii);
        if (a == ALG_PR) return bw + (x << F_LOG2) + o + W_AW'(ii);
        return bw + x;
    endfunction

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= S_IDLE;  alg <= ALG_NN;
            ox <= '0;  oy <= '0;  base_r <= '0;  base_w <= '0;  off <= '0;
            i <= '0;  j <= '0;  wait_cnt <= '0;  acc <= '0;
            r_addr <= '0;  w_addr <= '0;  pixel_out <= '0;
            r_en <= 1'b0;  w_en <= 1'b0;  busy <= 1'b0;  done <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (bus.START) begin
                    alg <= alg_t'(bus.ALGORITHM);
                    ox <= '0;  oy <= '0;  base_r <= '0;  base_w <= '0;  off <= '0;
                    i <= '0;  j <= '0;  acc <= '0;  r_addr <= '0;
                    r_en <= 1'b1;  busy <= 1'b1;  done <= 1'b0;
                    state <= S_RD;
                end
                S_RD: begin
                    r_en     <= 1'b0;
                    wait_cnt <= 2'(RD_LAT - 1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt != 2'd0) begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end else if (alg == ALG_BA && !inner_last) begin
                        acc <= ba_sum;
                        i <= i_n;  j <= j_n;  off <= off_n;
                        r_addr <= rd_addr(alg, base_r, ox, off_n, i_n);
                        r_en <= 1'b1;
                        state <= S_RD;
                    end else begin
                        pixel_out <= (alg == ALG_BA) ? ba_out : bus.PIXEL_IN;
                        acc <= '0;
                        i <= '0;  j <= '0;  off <= '0;
                        w_addr <= wr_addr(alg, base_w, ox, '0, 3'd0);
                        w_en <= 1'b1;
                        state <= S_WR;
                    end
                end
                S_WR: begin
                    if (alg == ALG_PR && !inner_last) begin
                        i <= i_n;  j <= j_n;  off <= off_n;
                        w_addr <= wr_addr(alg, base_w, ox, off_n, i_n);
                    end else begin
                        w_en <= 1'b0;
                        i <= '0;  j <= '0;  off <= '0;
                        if (frame_last) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            ox <= ox_n;  oy <= oy_n;
                            base_r <= base_r_n;  base_w <= base_w_n;
                            r_addr <= rd_addr(alg, base_r_n, ox_n, '0, 3'd0);
                            r_en <= 1'b1;
                            state <= S_RD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.R_ADDR    = r_addr;
    assign bus.R_EN      = r_en;
    assign bus.PIXEL_OUT = pixel_out;
    assign bus.W_ADDR    = w_addr;
    assign bus.W_EN      = w_en;
    assign bus.BUSY      = busy;
    assign bus.done      = done;
endmodule
